// File: rtl/n1_ir_pkg.sv
// Shared constants for the N1 instruction register: FSM encoding, opcode
// class prefixes, field bit positions and the multi-cycle classifier.
package n1_ir_pkg;

   typedef logic [1:0] ir_state_t;

   localparam ir_state_t ST_EMPTY = 2'd0;
   localparam ir_state_t ST_CYC1  = 2'd1;
   localparam ir_state_t ST_CYC2  = 2'd2;

   // Class prefixes; CALL/JMP is identified by bit 15 alone.
   localparam logic       CLS_CAL  = 1'b1;
   localparam logic [2:0] CLS_BRA  = 3'b011;
   localparam logic [2:0] CLS_IJMP = 3'b010;
   localparam logic [2:0] CLS_MEM  = 3'b001;
   localparam logic [2:0] CLS_ALU  = 3'b000;

   localparam int CAL_BIT      = 15;
   localparam int CLS_HI       = 15;
   localparam int CLS_LO       = 13;
   localparam int AADR_HI      = 14;
   localparam int AADR_LO      = 1;
   localparam int RADR_HI      = 12;
   localparam int RADR_LO      = 0;
   localparam int MADR_HI      = 8;
   localparam int MADR_LO      = 1;
   localparam int MADR_SEL_BIT = 9;
   localparam int EOW_BIT      = 0;

   function automatic logic is_multi_cyc(input logic [15:0] opc, input logic multi_cyc_mem);
      logic res;
      res = 1'b0;
      if (opc[CAL_BIT] == CLS_CAL) begin
         res = 1'b1;
      end else begin
         case (opc[CLS_HI:CLS_LO])
            CLS_BRA, CLS_IJMP: res = 1'b1;
            CLS_MEM:           res = multi_cyc_mem;
            default:           res = 1'b0;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/n1_ir_if.sv
// Fetch, execution-control and program-bus AGU signals of the N1 instruction
// register, bundled so the IR and its environment connect through one port.
interface n1_ir_if;

   // Fetch handshake: an opcode transfers on every cycle where
   // fe2ir_vld_i and ir2fe_acc_o are both high. Fetch keeps the opcode
   // stable while vld is high and acc is low; acc never depends on vld.
   logic [15:0] fe2ir_opc_i;
   logic        fe2ir_vld_i;
   logic        ir2fe_acc_o;

   logic        exe2ir_stall_i;
   logic        ir2exe_vld_o;
   logic        ir2exe_last_o;

   logic        ir2pagu_eow_o;
   logic        ir2pagu_eow_postpone_o;
   logic        ir2pagu_jmp_or_cal_o;
   logic        ir2pagu_bra_o;
   logic        ir2pagu_scyc_o;
   logic        ir2pagu_mem_o;
   logic        ir2pagu_aadr_sel_o;
   logic        ir2pagu_madr_sel_o;
   logic [13:0] ir2pagu_aadr_o;
   logic [12:0] ir2pagu_radr_o;
   logic [7:0]  ir2pagu_madr_o;

   // IR side
   modport slave (
      input  fe2ir_opc_i, fe2ir_vld_i, exe2ir_stall_i,
      output ir2fe_acc_o, ir2exe_vld_o, ir2exe_last_o,
      output ir2pagu_eow_o, ir2pagu_eow_postpone_o, ir2pagu_jmp_or_cal_o,
      output ir2pagu_bra_o, ir2pagu_scyc_o, ir2pagu_mem_o,
      output ir2pagu_aadr_sel_o, ir2pagu_madr_sel_o,
      output ir2pagu_aadr_o, ir2pagu_radr_o, ir2pagu_madr_o
   );

   // Fetch / execution / AGU side
   modport master (
      output fe2ir_opc_i, fe2ir_vld_i, exe2ir_stall_i,
      input  ir2fe_acc_o, ir2exe_vld_o, ir2exe_last_o,
      input  ir2pagu_eow_o, ir2pagu_eow_postpone_o, ir2pagu_jmp_or_cal_o,
      input  ir2pagu_bra_o, ir2pagu_scyc_o, ir2pagu_mem_o,
      input  ir2pagu_aadr_sel_o, ir2pagu_madr_sel_o,
      input  ir2pagu_aadr_o, ir2pagu_radr_o, ir2pagu_madr_o
   );

endinterface

// File: rtl/n1_ir_dec.sv
// Combinational pre-decode of a held opcode into AGU fields and class strobes.
// Strobes are qualified by vld; address fields are raw slices.
module n1_ir_dec
   import n1_ir_pkg::*;
#(
   parameter int MULTI_CYC_MEM = 1
) (
   input  logic [15:0] opc,
   input  logic        vld,
   output logic        multi,
   output logic        eow_bit,
   output logic        jmp_or_cal,
   output logic        bra,
   output logic        scyc,
   output logic        mem,
   output logic        aadr_sel,
   output logic        madr_sel,
   output logic [13:0] aadr,
   output logic [12:0] radr,
   output logic [7:0]  madr
);

   localparam logic MCM = (MULTI_CYC_MEM != 0);

   logic [2:0] cls;
   logic       is_cal;
   logic       is_bra;
   logic       is_ijmp;
   logic       is_mem;
   logic       is_alu;

   assign cls     = opc[CLS_HI:CLS_LO];
   assign is_cal  = (opc[CAL_BIT] == CLS_CAL);
   assign is_bra  = !is_cal && (cls == CLS_BRA);
   assign is_ijmp = !is_cal && (cls == CLS_IJMP);
   assign is_mem  = !is_cal && (cls == CLS_MEM);
   assign is_alu  = !is_cal && (cls == CLS_ALU);

   assign multi = is_multi_cyc(opc, MCM);

   // Branch opcodes use bit 0 as part of the relative address, not as EOW.
   assign eow_bit = opc[EOW_BIT] & ~is_bra;

   assign jmp_or_cal = vld & (is_cal | is_ijmp);
   assign bra        = vld & is_bra;
   assign scyc       = vld & is_alu;
   assign mem        = vld & is_mem;
   assign aadr_sel   = vld & is_ijmp;
   assign madr_sel   = vld & is_mem & opc[MADR_SEL_BIT];

   assign aadr = opc[AADR_HI:AADR_LO];
   assign radr = opc[RADR_HI:RADR_LO];
   assign madr = opc[MADR_HI:MADR_LO];

endmodule

// File: rtl/n1_ir.sv
// N1 instruction register: holds each accepted opcode for one or two cycles
// and drives execution-control status plus decoded AGU signals.
module n1_ir
   import n1_ir_pkg::*;
#(
   parameter logic [15:0] RST_OPCODE    = 16'h0000,
   parameter int          MULTI_CYC_MEM = 1
) (
   input  logic      clk_i,
   input  logic      async_rst_n_i,
   input  logic      sync_rst_i,
   n1_ir_if.slave    bus,
   output ir_state_t dbg_state_o
);

   ir_state_t   state_q;
   ir_state_t   state_d;
   logic [15:0] ir_q;

   logic vld;
   logic multi;
   logic eow_bit;
   logic last;
   logic acc;
   logic load;

   assign vld = (state_q != ST_EMPTY);

   n1_ir_dec #(
      .MULTI_CYC_MEM (MULTI_CYC_MEM)
   ) u_dec (
      .opc        (ir_q),
      .vld        (vld),
      .multi      (multi),
      .eow_bit    (eow_bit),
      .jmp_or_cal (bus.ir2pagu_jmp_or_cal_o),
      .bra        (bus.ir2pagu_bra_o),
      .scyc       (bus.ir2pagu_scyc_o),
      .mem        (bus.ir2pagu_mem_o),
      .aadr_sel   (bus.ir2pagu_aadr_sel_o),
      .madr_sel   (bus.ir2pagu_madr_sel_o),
      .aadr       (bus.ir2pagu_aadr_o),
      .radr       (bus.ir2pagu_radr_o),
      .madr       (bus.ir2pagu_madr_o)
   );

   assign last = ((state_q == ST_CYC1) & ~multi) | (state_q == ST_CYC2);

   // Accept is held low during either reset so nothing transfers into a
   // register that is being cleared.
   assign acc  = async_rst_n_i & ~sync_rst_i & ~bus.exe2ir_stall_i &
                 ((state_q == ST_EMPTY) | last);
   assign load = bus.fe2ir_vld_i & acc;

   always_comb begin
      state_d = state_q;
      if (bus.exe2ir_stall_i) begin
         state_d = state_q;
      end else if (load) begin
         state_d = ST_CYC1;
      end else if ((state_q == ST_CYC1) && multi) begin
         state_d = ST_CYC2;
      end else begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         state_q <= ST_EMPTY;
         ir_q    <= RST_OPCODE;
      end else if (sync_rst_i) begin
         state_q <= ST_EMPTY;
         ir_q    <= RST_OPCODE;
      end else begin
         state_q <= state_d;
         if (load) begin
            ir_q <= bus.fe2ir_opc_i;
         end
      end
   end

   assign bus.ir2fe_acc_o            = acc;
   assign bus.ir2exe_vld_o           = vld;
   assign bus.ir2exe_last_o          = last;
   // EOW of a multi-cycle word is announced in CYC1 and delivered in CYC2.
   assign bus.ir2pagu_eow_o          = last & eow_bit;
   assign bus.ir2pagu_eow_postpone_o = (state_q == ST_CYC1) & multi & eow_bit;

   assign dbg_state_o = state_q;

endmodule

// File: doc/n1_ir.md
Name: n1_ir

Overview:
Instruction register and pre-decode stage of the N1 core. It accepts 16-bit opcodes from the fetch stage over a valid/accept handshake and holds each one for the instruction's full execution (one or two cycles). It decodes the held opcode into the ir2pagu_* field and control signals consumed directly by the program bus AGU. It also supplies stage-valid and single-/multi-cycle status to the execution control.

Parameters:
- RST_OPCODE, 16'h0000, opcode loaded into IR on reset (decodes as single-cycle NOP, EOW=0)
- MULTI_CYC_MEM, 1, 1: memory I/O instructions take two cycles; 0: one cycle

Ports:
- clk_i  in  1  system clock
- async_rst_n_i  in  1  asynchronous reset, active low
- sync_rst_i  in  1  synchronous reset, active high, same effect as async reset
- fe2ir_opc_i  in  16  fetched opcode
- fe2ir_vld_i  in  1  fetched opcode valid
- ir2fe_acc_o  out  1  IR accepts opcode this cycle
- exe2ir_stall_i  in  1  execution stalls; IR must hold state
- ir2exe_vld_o  out  1  IR holds an executing instruction
- ir2exe_last_o  out  1  current cycle is the instruction's last cycle
- ir2pagu_eow_o  out  1  end-of-word bit of held opcode
- ir2pagu_eow_postpone_o  out  1  EOW deferred to second cycle
- ir2pagu_jmp_or_cal_o  out  1  jump or call
- ir2pagu_bra_o  out  1  conditional branch
- ir2pagu_scyc_o  out  1  single-cycle instruction
- ir2pagu_mem_o  out  1  memory I/O
- ir2pagu_aadr_sel_o  out  1  indirect absolute address (from PS0)
- ir2pagu_madr_sel_o  out  1  indirect data address (from PS0)
- ir2pagu_aadr_o  out  14  direct absolute address
- ir2pagu_radr_o  out  13  direct relative address
- ir2pagu_madr_o  out  8  direct memory address

Behaviour:
- Opcode map (opc = held IR):
  - opc[15]=1: CALL/JMP. aadr=opc[14:1], eow=opc[0], jmp_or_cal=1, two cycles.
  - opc[15:13]=011: BRA. radr=opc[12:0], bra=1, eow=0, two cycles.
  - opc[15:13]=010: indirect JMP. aadr_sel=1, jmp_or_cal=1, eow=opc[0], two cycles.
  - opc[15:13]=001: MEM. madr=opc[8:1], madr_sel=opc[9], mem=1, eow=opc[0]. Two cycles if MULTI_CYC_MEM, else one.
  - opc[15:13]=000: ALU/stack. scyc=1, eow=opc[0], one cycle.
- Field outputs are pure slices of the IR and are always driven. Control strobes are gated by ir2exe_vld_o, so they read 0 when the IR is empty.
- FSM states: EMPTY, CYC1, CYC2. State, IR and all registered outputs are reset by async_rst_n_i=0 (async) or sync_rst_i=1 (sync).
- Reset values: state=EMPTY, IR=RST_OPCODE, all strobe outputs 0, ir2fe_acc_o=0.
- ir2fe_acc_o (combinational) = !exe2ir_stall_i & (state==EMPTY | ir2exe_last_o).
- Load: fe2ir_vld_i & ir2fe_acc_o → IR<=fe2ir_opc_i, state<=CYC1, next cycle. One cycle of load latency.
- CYC1, no stall:
  - multi-cycle opcode → CYC2.
  - single-cycle opcode → CYC1 on a new load, EMPTY if no opcode is valid.
- CYC2, no stall: → CYC1 on a new load, else EMPTY.
- Any stall: state and IR hold. ir2fe_acc_o=0.
- ir2exe_last_o = (CYC1 & single-cycle) | CYC2.
- ir2pagu_eow_postpone_o = CYC1 & multi-cycle & opc eow bit. ir2pagu_eow_o is asserted only when last=1: in CYC2 for postponed words, in CYC1 for single-cycle words.
- Back-to-back single-cycle opcodes sustain one instruction per cycle with no bubble.
- Reset mid-instruction aborts it; the pending opcode is lost.
- fe2ir_vld_i while a stall is active: no accept, IR unchanged. Fetch must hold the opcode stable.

Decomposition:
- Package n1_ir_pkg holds:
  - FSM state enum.
  - Opcode class prefix constants (CAL, BRA, IJMP, MEM, ALU) and field bit-position localparams.
  - A function is_multi_cyc(opc, MULTI_CYC_MEM).
- Sub-module n1_ir_dec: purely combinational opcode → ir2pagu_* fields/strobes, reused by the formal bench. FSM and register stay in n1_ir.

Test Plan:
- Reset with valid opcode present → all strobes 0, acc=0 while async_rst_n_i=0. First rising edge after release with vld=1, opc=16'h0003 → IR loads; next cycle scyc=1, eow=1, last=1.
- Stream 16'h0002, 16'h0004, 16'h0006 with vld=1, no stall → acc=1 every cycle, three consecutive CYC1 cycles, no EMPTY in between.
- opc=16'h8001 (CAL aadr=14'h0000, eow=1) → CYC1: jmp_or_cal=1, eow_postpone=1, eow=0, acc=0; CYC2: eow=1, last=1, acc=1.
- opc=16'h6ABC (BRA radr=13'h0ABC) with stall asserted in CYC1 for 3 cycles → state, IR and outputs frozen for 3 cycles, then CYC2 then next load.
- MEM opc=16'h2203 (madr_sel=1, madr=8'h01, eow=1), MULTI_CYC_MEM=0 vs 1 → one-cycle with eow in CYC1 vs two-cycle with postpone.
- async_rst_n_i pulsed low mid-CYC1 of 16'h8001 → immediate return to EMPTY, IR=RST_OPCODE, no CYC2 follows.
